tdm_demux: RTL and testbench

Time-division demultiplexer: the receive-side counterpart of the team's mux-based selection logic. It takes one serial stream of WIDTH-bit samples, interleaved round-robin over CHANNELS slots and framed by a sync marker on slot 0, and distributes each sample into a per-channel holding register. It sits behind any TDM source in the design and presents parallel channel data plus update and frame strobes to downstream logic.

---
 rtl/tdm_demux.sv | 109 ++++++++++
 tb/tb_tdm_demux.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/tdm_demux.sv
// Time-division demux: one round-robin sample stream in, per-channel holding registers out.
// Latency: 1 cycle from accepted sample to ch_data/ch_upd/frame_valid/sync_err.
// Backpressure: none; one sample per cycle accepted, din_valid=0 cycles are ignored.
module tdm_demux #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH-1:0]            din,
    input  logic                        din_valid,
    input  logic                        sync,
    output logic [CHANNELS*WIDTH-1:0]   ch_data,
    output logic [CHANNELS-1:0]         ch_upd,
    output logic                        frame_valid,
    output logic                        locked,
    output logic                        sync_err
);
    localparam int SW = $clog2(CHANNELS);
    localparam logic [SW-1:0] LAST_SLOT = SW'(CHANNELS - 1);
    localparam logic [SW-1:0] SLOT_ONE  = SW'(1);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t                      state_q, state_d;
    logic [SW-1:0]               slot_q, slot_d;
    logic [CHANNELS*WIDTH-1:0]   data_q, data_d;
    logic [CHANNELS-1:0]         upd_q, upd_d;
    logic                        fv_q, fv_d;
    logic                        err_q, err_d;
    logic                        wr_en;
    logic [SW-1:0]               wr_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
            slot_q  <= '0;
            data_q  <= '0;
            upd_q   <= '0;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            data_q  <= data_d;
            upd_q   <= upd_d;
            fv_q    <= fv_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        fv_d    = 1'b0;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = '0;
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (sync) begin
                        wr_en   = 1'b1;
                        slot_d  = SLOT_ONE;
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (sync) begin
                        // Early sync abandons the partial frame and restarts at slot 0.
                        err_d  = (slot_q != '0);
                        wr_en  = 1'b1;
                        slot_d = SLOT_ONE;
                    end else if (slot_q == '0) begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                    end else begin
                        wr_en  = 1'b1;
                        wr_idx = slot_q;
                        if (slot_q == LAST_SLOT) begin
                            fv_d   = 1'b1;
                            slot_d = '0;
                        end else begin
                            slot_d = slot_q + SLOT_ONE;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        data_d = data_q;
        upd_d  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_en && (wr_idx == SW'(i))) begin
                data_d[i*WIDTH +: WIDTH] = din;
                upd_d[i]                 = 1'b1;
            end
        end
    end

    assign ch_data     = data_q;
    assign ch_upd      = upd_q;
    assign frame_valid = fv_q;
    assign sync_err    = err_q;
    assign locked      = (state_q == LOCKED);
endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux: a 4-channel and a 3-channel instance on one clock.
module tb_tdm_demux;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  din = '0, din3 = '0;
    logic        din_valid = 1'b0, sync = 1'b0;
    logic        din_valid3 = 1'b0, sync3 = 1'b0;
    logic [15:0] ch_data;
    logic [3:0]  ch_upd;
    logic        frame_valid, locked, sync_err;
    logic [11:0] ch_data3;
    logic [2:0]  ch_upd3;
    logic        frame_valid3, locked3, sync_err3;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tdm_demux #(.WIDTH(4), .CHANNELS(4)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
        .ch_data(ch_data), .ch_upd(ch_upd), .frame_valid(frame_valid),
        .locked(locked), .sync_err(sync_err)
    );

    tdm_demux #(.WIDTH(4), .CHANNELS(3)) dut3 (
        .clk(clk), .rst(rst), .din(din3), .din_valid(din_valid3), .sync(sync3),
        .ch_data(ch_data3), .ch_upd(ch_upd3), .frame_valid(frame_valid3),
        .locked(locked3), .sync_err(sync_err3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of input on the 4-channel instance, then sample 1 ns after the edge.
    task automatic step(input logic v, input logic s, input logic [3:0] d);
        din_valid = v;
        sync      = s;
        din       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step3(input logic v, input logic s, input logic [3:0] d);
        din_valid3 = v;
        sync3      = s;
        din3       = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_data", ch_data, 16'h0);
        chk("rst_upd", ch_upd, 4'h0);
        chk("rst_fv", frame_valid, 1'b0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_err", sync_err, 1'b0);
        chk("rst_data3", ch_data3, 12'h0);
        @(negedge clk);
        rst = 1'b0;

        // Hunt: unsynced samples are discarded
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 4'(i + 5));
            chk("hunt_upd", ch_upd, 4'h0);
            chk("hunt_locked", locked, 1'b0);
        end
        chk("hunt_data", ch_data, 16'h0);

        // Clean frame A,B,C,D
        step(1'b1, 1'b1, 4'hA);
        chk("clean_upd0", ch_upd, 4'b0001);
        chk("clean_locked", locked, 1'b1);
        chk("clean_fv0", frame_valid, 1'b0);
        step(1'b1, 1'b0, 4'hB);
        chk("clean_upd1", ch_upd, 4'b0010);
        step(1'b1, 1'b0, 4'hC);
        chk("clean_upd2", ch_upd, 4'b0100);
        chk("clean_fv2", frame_valid, 1'b0);
        step(1'b1, 1'b0, 4'hD);
        chk("clean_upd3", ch_upd, 4'b1000);
        chk("clean_fv3", frame_valid, 1'b1);
        chk("clean_data", ch_data, 16'hDCBA);
        step(1'b0, 1'b0, 4'h0);
        chk("idle_upd", ch_upd, 4'h0);
        chk("idle_fv", frame_valid, 1'b0);

        // Gapped frame 1,2,_,_,3,4
        step(1'b1, 1'b1, 4'h1);
        step(1'b1, 1'b0, 4'h2);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 4'hF);
            chk("gap_upd", ch_upd, 4'h0);
            chk("gap_fv", frame_valid, 1'b0);
            chk("gap_data", ch_data, 16'hDC21);
        end
        step(1'b1, 1'b0, 4'h3);
        chk("gap_upd2", ch_upd, 4'b0100);
        step(1'b1, 1'b0, 4'h4);
        chk("gap_fv_end", frame_valid, 1'b1);
        chk("gap_data_end", ch_data, 16'h4321);

        // Early sync: 5,6 then 9 with sync
        step(1'b1, 1'b1, 4'h5);
        step(1'b1, 1'b0, 4'h6);
        chk("early_pre_err", sync_err, 1'b0);
        step(1'b1, 1'b1, 4'h9);
        chk("early_err", sync_err, 1'b1);
        chk("early_upd", ch_upd, 4'b0001);
        chk("early_fv", frame_valid, 1'b0);
        chk("early_data", ch_data, 16'h4369);
        chk("early_locked", locked, 1'b1);
        step(1'b1, 1'b0, 4'hA);
        chk("early_upd1", ch_upd, 4'b0010);
        chk("early_err_clr", sync_err, 1'b0);
        step(1'b1, 1'b0, 4'hB);
        chk("early_upd2", ch_upd, 4'b0100);
        step(1'b1, 1'b0, 4'hC);
        chk("early_upd3", ch_upd, 4'b1000);
        chk("early_fv_end", frame_valid, 1'b1);
        chk("early_data_end", ch_data, 16'hCBA9);

        // Missing sync after a complete frame
        step(1'b1, 1'b0, 4'h7);
        chk("miss_err", sync_err, 1'b1);
        chk("miss_locked", locked, 1'b0);
        chk("miss_upd", ch_upd, 4'h0);
        chk("miss_data", ch_data, 16'hCBA9);
        step(1'b1, 1'b0, 4'h8);
        chk("miss_hunt_err", sync_err, 1'b0);
        chk("miss_hunt_upd", ch_upd, 4'h0);
        step(1'b1, 1'b1, 4'h2);
        chk("relock_data", ch_data, 16'hCBA2);
        chk("relock_locked", locked, 1'b1);
        chk("relock_upd", ch_upd, 4'b0001);

        // Reset mid-frame
        step(1'b1, 1'b0, 4'h5);
        chk("mid_data", ch_data, 16'hCB52);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_data", ch_data, 16'h0);
        chk("midrst_upd", ch_upd, 4'h0);
        chk("midrst_locked", locked, 1'b0);
        @(negedge clk);
        din_valid = 1'b0;
        rst       = 1'b0;

        // Three-channel instance: two frames
        step3(1'b1, 1'b1, 4'h1);
        chk("c3_upd0", ch_upd3, 3'b001);
        chk("c3_locked", locked3, 1'b1);
        step3(1'b1, 1'b0, 4'h2);
        chk("c3_upd1", ch_upd3, 3'b010);
        step3(1'b1, 1'b0, 4'h3);
        chk("c3_upd2", ch_upd3, 3'b100);
        chk("c3_fv", frame_valid3, 1'b1);
        chk("c3_data", ch_data3, 12'h321);
        step3(1'b1, 1'b1, 4'h4);
        chk("c3_wrap_upd", ch_upd3, 3'b001);
        chk("c3_wrap_err", sync_err3, 1'b0);
        chk("c3_wrap_fv", frame_valid3, 1'b0);
        step3(1'b1, 1'b0, 4'h5);
        step3(1'b1, 1'b0, 4'h6);
        chk("c3_fv2", frame_valid3, 1'b1);
        chk("c3_data2", ch_data3, 12'h654);
        step3(1'b0, 1'b0, 4'h0);
        chk("c3_idle_fv", frame_valid3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
